// File: rtl/goldschmidt_divider.sv
// goldschmidt_divider: FSM-sequenced Goldschmidt N/D with one shared RNE multiplier
// GSDIV_DIVZERO_EN adds d==0 bypass straight to DONE and the div_zero flag
module goldschmidt_divider #(
  parameter int WIDTH = 16,
  parameter int ITERS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] ia,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef GSDIV_DIVZERO_EN
  ,
  output logic             div_zero
`endif
);
  localparam int CW = $clog2(ITERS + 1);
`ifdef GSDIV_DIVZERO_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MUL_D, MUL_N, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, d_q, d_d, k_q, k_d, result_q, result_d, rnd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0] sum;
  logic accept, zero_in, last;
  if (ITERS < 1 || ITERS > 15) begin : g_iters_check
    $error("goldschmidt_divider: ITERS must be in 1..15");
  end
  assign accept  = state_q == IDLE && in_valid;
  assign zero_in = DZ && d == '0;
  assign last    = cnt_q == CW'(ITERS - 1);
  // Q2 product back to Q1: keep P[2W-2:W-1], round half to even, saturate at >= 2.0
  always_comb begin
    p   = {{WIDTH{1'b0}}, (state_q == MUL_D ? d_q : n_q)} * {{WIDTH{1'b0}}, k_q};
    sum = {1'b0, p[2*WIDTH-2:WIDTH-1]} + (WIDTH+1)'(p[WIDTH-2] && ((|p[WIDTH-3:0]) || p[WIDTH-1]));
    rnd = (p[2*WIDTH-1] || sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
  end
  always_comb begin
    state_d = state_q == IDLE  ? (in_valid ? (zero_in ? DONE : MUL_D) : IDLE)
            : state_q == MUL_D ? MUL_N
            : state_q == MUL_N ? (last ? DONE : MUL_D)
            : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    n_d      = accept ? n  : state_q == MUL_N ? rnd : n_q;
    d_d      = accept ? d  : state_q == MUL_D ? rnd : d_q;
    k_d      = accept ? ia : state_q == MUL_N ? -d_q : k_q;
    cnt_d    = accept ? '0 : state_q == MUL_N ? cnt_q + CW'(1) : cnt_q;
    result_d = (accept && zero_in) ? '1 : (state_q == MUL_N && last) ? rnd : result_q;
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    busy      = state_q != IDLE;
    out_valid = state_q == DONE;
    result    = result_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      d_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
`ifdef GSDIV_DIVZERO_EN
  logic div_zero_q, div_zero_d;
  always_comb begin
    div_zero_d = (accept && zero_in) ? 1'b1 : (state_q == DONE && out_ready) ? 1'b0 : div_zero_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) div_zero_q <= 1'b0;
    else div_zero_q <= div_zero_d;
  end
  assign div_zero = div_zero_q;
`endif
endmodule
